// File: rtl/ahb_rr_arbiter.sv
// AHB bus arbiter: round-robin or fixed-priority grant of a shared bus, with
// bridge-side handshake for remote slaves and a hold-time watchdog.
module ahb_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int SEL_W       = 4,
    parameter int RR_EN       = 1,
    parameter int MAX_HOLD    = 16,
    localparam int OW         = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                         hclk,
    input  logic                         hreset,
    input  logic [NUM_MASTERS-1:0]       hreq,
    input  logic [NUM_MASTERS*SEL_W-1:0] sel_in,
    input  logic                         hready_out,
    input  logic                         hresp,
    input  logic                         hgrantb,
    output logic [NUM_MASTERS-1:0]       hgrant,
    output logic [SEL_W-1:0]             sel,
    output logic                         hreqb,
    output logic [OW-1:0]                owner,
    output logic                         busy,
    output logic                         err_o,
    output logic                         timeout_o
);

    localparam int CW = (MAX_HOLD > 0) ? (($clog2(MAX_HOLD + 1) > 0) ? $clog2(MAX_HOLD + 1) : 1) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic [OW-1:0] PTR_RST   = OW'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_GRANT       = 2'd1,
        S_BRIDGE_WAIT = 2'd2,
        S_BRIDGE      = 2'd3
    } state_t;

    state_t                   r_state, w_state_n;
    logic [NUM_MASTERS-1:0]   r_hgrant, w_hgrant_n;
    logic [SEL_W-1:0]         r_sel, w_sel_n;
    logic                     r_hreqb, w_hreqb_n;
    logic [OW-1:0]            r_owner, w_owner_n;
    logic [OW-1:0]            r_rr_ptr, w_rr_ptr_n;
    logic                     r_busy, w_busy_n;
    logic                     r_err, w_err_n;
    logic                     r_tmo, w_tmo_n;
    logic [CW-1:0]            r_cnt, w_cnt_n;

    logic                     w_found;
    logic [OW-1:0]            w_win;
    logic [OW-1:0]            w_base;
    logic [SEL_W-1:0]         w_win_sel;
    logic                     w_win_bridge;
    logic                     w_done;
    logic                     w_err;
    logic                     w_wd_exp;

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [OW-1:0] idx);
        logic [NUM_MASTERS-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign w_done   = hready_out & ~hresp;
    assign w_err    = hready_out & hresp;
    assign w_wd_exp = (MAX_HOLD != 0) && (r_cnt == HOLD_LAST) && !w_done && !w_err;

    // Fixed priority reuses the rotating search with the pointer pinned at the top index.
    assign w_base = (RR_EN != 0) ? r_rr_ptr : PTR_RST;

    // Winner search: first requester after the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            int idx;
            idx = (int'(w_base) + k) % NUM_MASTERS;
            if (!w_found && hreq[idx]) begin
                w_found = 1'b1;
                w_win   = OW'(idx);
            end else begin
                w_found = w_found;
            end
        end
    end

    assign w_win_sel    = sel_in[int'(w_win)*SEL_W +: SEL_W];
    assign w_win_bridge = |w_win_sel[SEL_W-1:SEL_W-2];

    // Next-state and next-output logic.
    always_comb begin
        w_state_n  = r_state;
        w_hgrant_n = r_hgrant;
        w_sel_n    = r_sel;
        w_hreqb_n  = r_hreqb;
        w_owner_n  = r_owner;
        w_rr_ptr_n = r_rr_ptr;
        w_busy_n   = r_busy;
        w_err_n    = 1'b0;
        w_tmo_n    = 1'b0;
        w_cnt_n    = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_sel_n    = w_win_sel;
                    w_owner_n  = w_win;
                    w_rr_ptr_n = w_win;
                    w_busy_n   = 1'b1;
                    w_cnt_n    = '0;
                    if (w_win_bridge) begin
                        w_state_n = S_BRIDGE_WAIT;
                        w_hreqb_n = 1'b1;
                    end else begin
                        w_state_n  = S_GRANT;
                        w_hgrant_n = onehot(w_win);
                    end
                end else begin
                    w_state_n = S_IDLE;
                end
            end
            S_GRANT, S_BRIDGE: begin
                if (w_done || w_err || w_wd_exp) begin
                    w_state_n  = S_IDLE;
                    w_hgrant_n = '0;
                    w_sel_n    = '0;
                    w_hreqb_n  = 1'b0;
                    w_busy_n   = 1'b0;
                    w_err_n    = w_err;
                    w_tmo_n    = w_wd_exp;
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end
            S_BRIDGE_WAIT: begin
                // A bridge grant takes precedence over the owner withdrawing.
                if (hgrantb) begin
                    w_state_n  = S_BRIDGE;
                    w_hgrant_n = onehot(r_owner);
                    w_cnt_n    = '0;
                end else if (!hreq[r_owner]) begin
                    w_state_n = S_IDLE;
                    w_hreqb_n = 1'b0;
                    w_sel_n   = '0;
                    w_busy_n  = 1'b0;
                end else begin
                    w_state_n = S_BRIDGE_WAIT;
                end
            end
            default: begin
                w_state_n  = S_IDLE;
                w_hgrant_n = '0;
                w_sel_n    = '0;
                w_hreqb_n  = 1'b0;
                w_busy_n   = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state  <= S_IDLE;
            r_hgrant <= '0;
            r_sel    <= '0;
            r_hreqb  <= 1'b0;
            r_owner  <= '0;
            r_rr_ptr <= PTR_RST;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_tmo    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_n;
            r_hgrant <= w_hgrant_n;
            r_sel    <= w_sel_n;
            r_hreqb  <= w_hreqb_n;
            r_owner  <= w_owner_n;
            r_rr_ptr <= w_rr_ptr_n;
            r_busy   <= w_busy_n;
            r_err    <= w_err_n;
            r_tmo    <= w_tmo_n;
            r_cnt    <= w_cnt_n;
        end
    end

    assign hgrant    = r_hgrant;
    assign sel       = r_sel;
    assign hreqb     = r_hreqb;
    assign owner     = r_owner;
    assign busy      = r_busy;
    assign err_o     = r_err;
    assign timeout_o = r_tmo;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed bench for ahb_rr_arbiter: a round-robin instance and a
// fixed-priority instance share all inputs.
module tb_ahb_rr_arbiter;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [3:0]  hreq;
    logic [15:0] sel_in;
    logic        hready_out;
    logic        hresp;
    logic        hgrantb;

    logic [3:0]  hgrant, fp_hgrant;
    logic [3:0]  sel, fp_sel;
    logic        hreqb, fp_hreqb;
    logic [1:0]  owner, fp_owner;
    logic        busy, fp_busy;
    logic        err_o, fp_err_o;
    logic        timeout_o, fp_timeout_o;

    int checks = 0;
    int errors = 0;

    ahb_rr_arbiter #(.NUM_MASTERS(4), .SEL_W(4), .RR_EN(1), .MAX_HOLD(16)) dut (
        .hclk(hclk), .hreset(hreset), .hreq(hreq), .sel_in(sel_in),
        .hready_out(hready_out), .hresp(hresp), .hgrantb(hgrantb),
        .hgrant(hgrant), .sel(sel), .hreqb(hreqb), .owner(owner),
        .busy(busy), .err_o(err_o), .timeout_o(timeout_o)
    );

    ahb_rr_arbiter #(.NUM_MASTERS(4), .SEL_W(4), .RR_EN(0), .MAX_HOLD(16)) dut_fp (
        .hclk(hclk), .hreset(hreset), .hreq(hreq), .sel_in(sel_in),
        .hready_out(hready_out), .hresp(hresp), .hgrantb(hgrantb),
        .hgrant(fp_hgrant), .sel(fp_sel), .hreqb(fp_hreqb), .owner(fp_owner),
        .busy(fp_busy), .err_o(fp_err_o), .timeout_o(fp_timeout_o)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_hgrant"}, 32'(hgrant), 32'h0);
        check({tag, "_sel"}, 32'(sel), 32'h0);
        check({tag, "_hreqb"}, 32'(hreqb), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_err"}, 32'(err_o), 32'h0);
        check({tag, "_tmo"}, 32'(timeout_o), 32'h0);
    endtask

    initial begin
        hreset = 1'b1; hreq = 4'h0; sel_in = 16'h0000;
        hready_out = 1'b0; hresp = 1'b0; hgrantb = 1'b0;
        tick(); tick();
        check_idle_outputs("rst");
        check("rst_owner", 32'(owner), 32'h0);
        hreset = 1'b0;

        // Basic local grant, done after 3 cycles
        hreq = 4'b0001; sel_in = 16'h0001;
        tick();
        check("g1_hgrant", 32'(hgrant), 32'h1);
        check("g1_sel", 32'(sel), 32'h1);
        check("g1_busy", 32'(busy), 32'h1);
        check("g1_owner", 32'(owner), 32'h0);
        hreq = 4'b0000;
        tick(); tick();
        check("g1_hold", 32'(hgrant), 32'h1);
        hready_out = 1'b1;
        tick();
        check_idle_outputs("g1_done");
        hready_out = 1'b0;

        // Round-robin vs fixed priority, all requesting, done every grant cycle
        hreset = 1'b1; #1;
        hreset = 1'b0;
        hreq = 4'b1111; sel_in = 16'h3121; hready_out = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("rr_grant%0d", i), 32'(hgrant), 32'(1 << (i % 4)));
            check($sformatf("fp_grant%0d", i), 32'(fp_hgrant), 32'h1);
            tick();
            check($sformatf("rr_gap%0d", i), 32'(hgrant), 32'h0);
            check($sformatf("fp_gap%0d", i), 32'(fp_hgrant), 32'h0);
        end
        check("rr_owner_last", 32'(owner), 32'h0);
        hreq = 4'b0000; hready_out = 1'b0;
        tick();

        // Bridge-targeted master 2
        hreq = 4'b0100; sel_in = 16'h0800;
        tick();
        check("br_hreqb", 32'(hreqb), 32'h1);
        check("br_wait_hgrant", 32'(hgrant), 32'h0);
        check("br_busy", 32'(busy), 32'h1);
        check("br_owner", 32'(owner), 32'h2);
        check("br_sel", 32'(sel), 32'h8);
        tick(); tick(); tick();
        check("br_still_wait", 32'(hgrant), 32'h0);
        hgrantb = 1'b1;
        tick();
        check("br_hgrant", 32'(hgrant), 32'h4);
        check("br_hreqb_hold", 32'(hreqb), 32'h1);
        hgrantb = 1'b0; hready_out = 1'b1;
        tick();
        check_idle_outputs("br_done");
        hready_out = 1'b0;

        // Bridge wait abandoned by master 2
        tick();
        check("ab_hreqb", 32'(hreqb), 32'h1);
        hreq = 4'b0000;
        tick();
        check_idle_outputs("ab_idle");
        tick();
        check("ab_no_grant", 32'(hgrant), 32'h0);

        // Watchdog: 16 grant cycles then forced release
        hreq = 4'b0001; sel_in = 16'h0001;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("wd_hold%0d", i), 32'(hgrant), 32'h1);
            check($sformatf("wd_notmo%0d", i), 32'(timeout_o), 32'h0);
        end
        hreq = 4'b0000;
        tick();
        check("wd_release", 32'(hgrant), 32'h0);
        check("wd_tmo", 32'(timeout_o), 32'h1);
        check("wd_busy", 32'(busy), 32'h0);
        tick();
        check("wd_tmo_pulse", 32'(timeout_o), 32'h0);

        // Done on the 16th grant cycle beats the watchdog
        hreq = 4'b0001;
        for (int i = 1; i <= 16; i++) begin
            tick();
        end
        check("wd2_hold16", 32'(hgrant), 32'h1);
        hreq = 4'b0000; hready_out = 1'b1;
        tick();
        check("wd2_release", 32'(hgrant), 32'h0);
        check("wd2_no_tmo", 32'(timeout_o), 32'h0);
        hready_out = 1'b0;
        tick();

        // Error completion
        hreq = 4'b0001;
        tick();
        check("er_grant", 32'(hgrant), 32'h1);
        hreq = 4'b0000; hready_out = 1'b1; hresp = 1'b1;
        tick();
        check("er_release", 32'(hgrant), 32'h0);
        check("er_pulse", 32'(err_o), 32'h1);
        hready_out = 1'b0; hresp = 1'b0;
        tick();
        check("er_pulse_end", 32'(err_o), 32'h0);

        // Asynchronous reset in the middle of a bridge transfer
        hreq = 4'b0100; sel_in = 16'h0800;
        tick();
        hgrantb = 1'b1;
        tick();
        check("rb_hgrant", 32'(hgrant), 32'h4);
        #1 hreset = 1'b1;
        #1;
        check_idle_outputs("rb_async");
        check("rb_owner", 32'(owner), 32'h0);
        hgrantb = 1'b0; hreq = 4'b0000;
        tick();
        hreset = 1'b0;
        tick();
        check("rb_after", 32'(hgrant), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
